// File: rtl/image_buffer_writer_if.sv
// rtl/image_buffer_writer_if.sv - pixel input stream and frame RAM write bus
//
// Groups the source pixel stream and the RAM write port of the image buffer writer.
//   vs_in    frame sync, active-high, rising edge = start of frame
//   de_in    data enable, high during active pixels of a line
//   data_in  RGB565 pixel, valid when de_in=1
//   wr_en    RAM write strobe
//   wr_addr  RAM write address
//   wr_data  RAM write data
// master: the pixel source / RAM side; slave: the writer block.
interface image_buffer_writer_if;
  logic        vs_in;
  logic        de_in;
  logic [15:0] data_in;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;

  modport master (
    output vs_in, de_in, data_in,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  vs_in, de_in, data_in,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/image_buffer_writer.sv
// rtl/image_buffer_writer.sv - decimating write side of the scaler frame RAM
//
// Decimates an RGB565 pixel stream by 2^DEC_SHIFT in both axes and writes the
// COL_PIXEL x ROW_PIXEL result row-major at wr_addr = y*COL_PIXEL + x.
//   clk         pixel/system clock
//   rst         synchronous reset, active-high
//   capture_en  capture successive frames; looked at only outside CAPTURE
//   bus         pixel stream in (vs_in/de_in/data_in), RAM write out (wr_en/wr_addr/wr_data)
//   busy        high while a frame is being captured
//   frame_done  1-cycle pulse after the last word of a frame is written
//   frame_err   1-cycle pulse when a frame is aborted by an early vs rising edge
module image_buffer_writer #(
  parameter int COL_PIXEL = 320,
  parameter int ROW_PIXEL = 180,
  parameter int DEC_SHIFT = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        capture_en,
  image_buffer_writer_if.slave        bus,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        frame_err
);

  localparam int XW = $clog2(COL_PIXEL + 1);
  localparam int YW = $clog2(ROW_PIXEL + 1);
  localparam logic [XW-1:0] COL_LIM = XW'(COL_PIXEL);
  localparam logic [YW-1:0] ROW_LIM = YW'(ROW_PIXEL);
  localparam logic [11:0]   SRC_MAX = 12'hFFF;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    CAPTURE
  } state_t;

  state_t state, state_nxt;

  logic          vs_q, de_q;
  logic          vs_rise, de_fall;
  logic [11:0]   src_x, src_y;
  logic [XW-1:0] dst_x;
  logic [YW-1:0] dst_y;
  logic [15:0]   row_base;
  logic          last_written;
  logic          keep, keep_last;
  logic          start_frame;
  logic          done_nxt, err_nxt;
  logic          wr_en_q;
  logic [15:0]   wr_addr_q, wr_data_q;

  assign vs_rise = bus.vs_in & ~vs_q;
  assign de_fall = de_q & ~bus.de_in;

  // A vs edge always wins over a coincident pixel, so that pixel is never kept.
  assign keep = (state == CAPTURE) && bus.de_in && !vs_rise &&
                (src_x[DEC_SHIFT-1:0] == '0) && (src_y[DEC_SHIFT-1:0] == '0) &&
                (dst_x < COL_LIM) && (dst_y < ROW_LIM);

  assign keep_last = keep && (dst_x == COL_LIM - 1'b1) && (dst_y == ROW_LIM - 1'b1);

  assign busy        = (state == CAPTURE);
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (capture_en) state_nxt = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (!capture_en) begin
          state_nxt = IDLE;
        end else if (vs_rise) begin
          state_nxt   = CAPTURE;
          start_frame = 1'b1;
        end
      end
      CAPTURE: begin
        // Completion outranks a coincident vs edge; that edge is then lost,
        // so the following frame is skipped.
        if (last_written) begin
          done_nxt  = 1'b1;
          state_nxt = capture_en ? WAIT_FRAME : IDLE;
        end else if (vs_rise) begin
          err_nxt     = 1'b1;
          start_frame = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      vs_q         <= 1'b0;
      de_q         <= 1'b0;
      src_x        <= '0;
      src_y        <= '0;
      dst_x        <= '0;
      dst_y        <= '0;
      row_base     <= '0;
      last_written <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_nxt;
      vs_q         <= bus.vs_in;
      de_q         <= bus.de_in;
      frame_done   <= done_nxt;
      frame_err    <= err_nxt;
      wr_en_q      <= keep;
      last_written <= keep_last;

      if (keep) begin
        wr_addr_q <= row_base + 16'(dst_x);
        wr_data_q <= bus.data_in;
      end

      if (start_frame) begin
        src_x    <= '0;
        src_y    <= '0;
        dst_x    <= '0;
        dst_y    <= '0;
        row_base <= '0;
      end else begin
        if (de_fall) begin
          src_x <= '0;
          if (src_y != SRC_MAX) src_y <= src_y + 1'b1;
          dst_x <= '0;
          // Only lines that produced a write advance the destination row.
          if (dst_x != '0) begin
            dst_y    <= dst_y + 1'b1;
            row_base <= row_base + 16'(COL_PIXEL);
          end
        end else begin
          if (bus.de_in && src_x != SRC_MAX) src_x <= src_x + 1'b1;
          if (keep) dst_x <= dst_x + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_image_buffer_writer.sv
// tb/tb_image_buffer_writer.sv - scoreboard bench for image_buffer_writer
module tb_image_buffer_writer;

  localparam int K_WR   = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int kind;
    int addr;
    int data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic capture_en = 1'b0;
  logic busy, frame_done, frame_err;

  image_buffer_writer_if bus();

  image_buffer_writer #(
    .COL_PIXEL(4),
    .ROW_PIXEL(2),
    .DEC_SHIFT(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .capture_en (capture_en),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   last_wr_cyc = -100;

  task automatic chk_eq(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  task automatic fail_now(input string name, input int act);
    checks++;
    $display("FAIL %s: got %0d expected nothing", name, act);
  endtask

  task automatic push(input int kind, input int addr, input int data);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every DUT event consumes the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_en) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_write", int'(bus.wr_addr));
        end else begin
          mon_e = exp_q.pop_front();
          chk_eq("event_is_write", K_WR, mon_e.kind);
          if (mon_e.kind == K_WR) begin
            chk_eq("wr_addr", int'(bus.wr_addr), mon_e.addr);
            chk_eq("wr_data", int'(bus.wr_data), mon_e.data);
          end
        end
        last_wr_cyc = cyc;
      end
      if (frame_done) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_frame_done", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk_eq("event_is_done", K_DONE, mon_e.kind);
          chk_eq("done_latency", cyc - last_wr_cyc, 1);
        end
      end
      if (frame_err) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_frame_err", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk_eq("event_is_err", K_ERR, mon_e.kind);
        end
      end
    end
  end

  // Drives one source frame of w x h pixels, data = tag*256 + y*w + x.
  // Window is 4x2 after decimation by 2, so pixel (x,y) is kept when both are
  // even and x/2 < 4, y/2 < 2; it lands at (y/2)*4 + x/2.
  task automatic drive_frame(input int w, input int h, input int tag, input int stop_at,
                             input bit with_vs, input bit cap, input bit err,
                             input bit tail, input bit tbl, input int drop_at);
    int kept;
    int t2 [8];
    t2 = '{0, 2, 4, 6, 16, 18, 20, 22};
    kept = 0;
    if (with_vs) begin
      if (err) push(K_ERR, 0, 0);
      bus.vs_in = 1'b1;
      tick();
      tick();
      bus.vs_in = 1'b0;
      tick();
      tick();
      chk_eq("busy_after_vs", int'(busy), int'(cap));
    end
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        bus.de_in   = 1'b1;
        bus.data_in = 16'(tag * 256 + y * w + x);
        if (cap && (x % 2 == 0) && (y % 2 == 0) && (x / 2 < 4) && (y / 2 < 2)) begin
          push(K_WR, (y / 2) * 4 + x / 2, tbl ? t2[kept] : tag * 256 + y * w + x);
          kept++;
          if (kept == 8) push(K_DONE, 0, 0);
        end
        tick();
        if (drop_at != 0 && kept == drop_at) capture_en = 1'b0;
        if (stop_at != 0 && kept == stop_at) begin
          bus.de_in = 1'b0;
          tick();
          return;
        end
      end
      if (tail && y == h - 1) begin
        bus.de_in = 1'b0;
        bus.vs_in = 1'b1;
        tick();
        tick();
      end else begin
        bus.de_in = 1'b0;
        repeat (3) tick();
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.vs_in   = 1'b0;
    bus.de_in   = 1'b0;
    bus.data_in = 16'h0000;
    rst = 1'b1;
    repeat (3) tick();
    chk_eq("rst_wr_en", int'(bus.wr_en), 0);
    chk_eq("rst_busy", int'(busy), 0);
    rst = 1'b0;
    capture_en = 1'b1;
    repeat (2) tick();

    // Small frame with table-driven expected data.
    drive_frame(8, 4, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    // Early vsync after 5 writes, then the replacement frame.
    drive_frame(8, 4, 1, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    drive_frame(8, 4, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    // Oversize source: surplus pixels and lines dropped.
    drive_frame(12, 6, 3, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Reset mid-stream after 3 writes.
    drive_frame(8, 4, 4, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    bus.de_in = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    chk_eq("mid_rst_wr_en", int'(bus.wr_en), 0);
    chk_eq("mid_rst_wr_addr", int'(bus.wr_addr), 0);
    chk_eq("mid_rst_wr_data", int'(bus.wr_data), 0);
    chk_eq("mid_rst_busy", int'(busy), 0);
    chk_eq("mid_rst_frame_done", int'(frame_done), 0);
    chk_eq("mid_rst_frame_err", int'(frame_err), 0);
    bus.de_in = 1'b0;
    rst = 1'b0;
    tick();
    drive_frame(8, 4, 5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk_eq("busy_no_vs_after_rst", int'(busy), 0);
    drive_frame(8, 4, 6, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // vs edge on the completion cycle: done wins, the next frame is skipped.
    drive_frame(7, 3, 7, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    drive_frame(8, 4, 8, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    drive_frame(8, 4, 9, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // capture_en dropped mid-frame: frame still completes, then IDLE.
    drive_frame(8, 4, 10, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    chk_eq("busy_after_drop", int'(busy), 0);
    drive_frame(8, 4, 11, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk_eq("busy_idle_frame", int'(busy), 0);

    repeat (20) tick();
    chk_eq("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
